hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Register-file scoreboard and writeback-port arbiter for the CPU pipeline. Tracks integer and FP destination registers owned by in-flight long-latency operations (load misses, FDIV/FSQRT) and stalls the D stage on RAW, WAW and structural hazards. Shares the single integer/FP register-file write port between the pipeline W stage and the long-latency unit (LU), with a starvation guard. Sits beside the D-stage forwarding control and consumes its source-usage flags.

## Interface
Parameters:
- MAX_OUT, 4, max long-latency operations in flight (1..15)
- STARVE_LIMIT, 3, consecutive denied LU-request cycles before the pipeline is held (1..15)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- D_valid  input  1  D stage holds a real instruction
- D_rs1, D_rs2, D_rd  input  5 each  D-stage register indices
- D_use_rs1, D_use_rs2, D_use_frs1, D_use_frs2  input  1 each  source-usage flags from D-stage decode
- D_use_rd, D_use_frd  input  1 each  D instruction writes int / FP rd through the pipeline
- D_long  input  1  D instruction is issued to the LU (its rd is written by the LU, not the pipeline)
- D_long_fp  input  1  LU destination is the FP file
- D_stall  output  1  hold D and upstream, inject bubble into E
- W_wen, W_fwen  input  1 each  W stage wants to write int / FP file this cycle
- lu_req  input  1  LU has a result ready
- lu_rd  input  5  LU result destination
- lu_fp  input  1  LU result targets FP file
- lu_gnt  output  1  LU result written this cycle
- hold_pipe  output  1  freeze entire pipeline one cycle; W write suppressed and re-presented
- rf_wsel  output  1  write-port mux select (WSEL_PIPE / WSEL_LU)
- outstanding  output  4  long ops in flight
- sb_err  output  1  sticky: LU granted to a register not marked busy

## Operation
- Busy tables: ibusy[31:0], fbusy[31:0]; ibusy[0] constant 0.
- Issue accepted = D_valid & D_long & ~D_stall: set busy[D_rd] of the class given by D_long_fp (int rd 0 not set); outstanding +1.
- lu_gnt: clear busy[lu_rd] of class lu_fp; outstanding −1. Accept and grant in the same cycle: count unchanged; both table updates apply (set wins on identical entry; cannot arise legally due to WAW stall).
- D_stall = D_valid & (RAW | WAW | STRUCT) | hold_pipe:
  - RAW: (D_use_rs1 & ibusy[rs1]) | (D_use_rs2 & ibusy[rs2]) | (D_use_frs1 & fbusy[rs1]) | (D_use_frs2 & fbusy[rs2]).
  - WAW: (D_use_rd & ibusy[rd]) | (D_use_frd & fbusy[rd]) | (D_long & busy[rd] of D_long_fp class).
  - STRUCT: D_long & (outstanding == MAX_OUT).
- Stall decisions use registered busy state only; no same-cycle bypass of a clear.
- Arbitration: pipe_w = (W_wen | W_fwen) & ~hold_pipe; lu_gnt = lu_req & (~pipe_w); rf_wsel = WSEL_LU iff lu_gnt, else WSEL_PIPE.
- Starve counter: increments on lu_req & ~lu_gnt, clears on lu_gnt or ~lu_req, saturates at STARVE_LIMIT. hold_pipe = lu_req & (starve_cnt == STARVE_LIMIT), forcing a grant that cycle.
- sb_err sets on lu_gnt with target busy bit already 0 (including int x0); cleared only by rst.

## Timing
- Reset (rst high at edge): busy tables 0, outstanding 0, starve_cnt 0, sb_err 0. While rst is high, lu_gnt, hold_pipe, D_stall forced 0; rf_wsel = WSEL_PIPE. Reset mid-operation discards all tracking; LU shares the same reset.
- Busy set visible from cycle after issue; dependent instruction stalls starting the next cycle it sits in D.
- Busy cleared at the grant edge; dependent D instruction un-stalls the following cycle (1-cycle penalty after writeback).
- lu_gnt, rf_wsel, hold_pipe, D_stall are combinational from inputs and registered state; zero latency.
- Worst-case LU wait: STARVE_LIMIT cycles denied, granted on cycle STARVE_LIMIT+1.
- outstanding never exceeds MAX_OUT and never underflows; grant at 0 is sb_err.

## Structure
- Shared CPU package: WSEL_PIPE = 1'b0, WSEL_LU = 1'b1; existing opcode defines unchanged.
- Sub-module busy_table (32-bit set/clear table, two read ports plus rd read port, optional hard-zero entry 0), instantiated twice (int with zero entry, FP without).
- Counters and arbitration in top level.

## Test plan
- Issue FDIV to f5, next D op FADD reading f5 -> D_stall high until lu_req grant at f5; released one cycle after lu_gnt.
- W_wen high continuously with lu_req high, STARVE_LIMIT=3 -> lu_gnt 0 for 3 cycles, cycle 4: hold_pipe=1, lu_gnt=1, rf_wsel=WSEL_LU.
- Issue 4 load misses to x1..x4 (MAX_OUT=4), 5th long op -> STRUCT stall, outstanding=4; one grant -> issue accepted next cycle.
- Issue + grant same cycle (x7 issue, x3 grant) -> outstanding unchanged, ibusy[7]=1, ibusy[3]=0.
- Long op to x0, then op reading x0 -> no stall; lu_gnt to x0 -> sb_err=1 sticky.
- rst asserted with 3 outstanding -> next cycle outstanding=0, all busy clear, no stalls.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared definitions for the register-file scoreboard / writeback arbiter:
//   - write-port mux select encodings (WSEL_PIPE / WSEL_LU)
//   - register index type
//   - one-hot decode helper used by the busy tables
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

  // Register-file write-port mux select.
  localparam logic WSEL_PIPE = 1'b0;
  localparam logic WSEL_LU   = 1'b1;

  // Architectural register index (32 entries per file).
  typedef logic [4:0] reg_idx_t;

  // Width of the in-flight and starvation counters.
  localparam int CNT_W = 4;

  // One-hot decode of a register index into a 32-bit table mask.
  function automatic logic [31:0] idx_mask(input reg_idx_t idx);
    logic [31:0] m;
    m = 32'd0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_busy_table.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_busy_table
// 32-entry busy bit table for one register file. One entry may be set and one
// cleared per cycle; when both hit the same entry the set wins. Entry 0 can be
// hard-wired to zero (integer x0).
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset (clears all bits)
//   i_set, i_set_idx  mark register busy (issue of a long-latency op)
//   i_clr, i_clr_idx  mark register free (long-latency writeback)
//   i_ra_idx/o_ra     source 1 read port
//   i_rb_idx/o_rb     source 2 read port
//   i_rd_idx/o_rd     destination read port (WAW check)
//   o_clr_hit         busy bit currently held at i_clr_idx (error check)
// -----------------------------------------------------------------------------
module hazard_scoreboard_busy_table
  import hazard_scoreboard_pkg::*;
#(
  parameter bit HARD_ZERO = 1'b0
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_set,
  input  reg_idx_t i_set_idx,
  input  logic     i_clr,
  input  reg_idx_t i_clr_idx,
  input  reg_idx_t i_ra_idx,
  input  reg_idx_t i_rb_idx,
  input  reg_idx_t i_rd_idx,
  output logic     o_ra,
  output logic     o_rb,
  output logic     o_rd,
  output logic     o_clr_hit
);

  // Entry 0 is masked off for the integer file so x0 can never look busy.
  localparam logic [31:0] KEEP_MASK = HARD_ZERO ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;

  logic [31:0] r_busy;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;
  logic [31:0] w_busy_nxt;

  // Build set/clear masks; set is applied after clear so it wins on a tie.
  always_comb begin
    w_set_mask = 32'd0;
    w_clr_mask = 32'd0;
    if (i_set) begin
      w_set_mask = idx_mask(i_set_idx) & KEEP_MASK;
    end else begin
      w_set_mask = 32'd0;
    end
    if (i_clr) begin
      w_clr_mask = idx_mask(i_clr_idx);
    end else begin
      w_clr_mask = 32'd0;
    end
    w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & KEEP_MASK;
  end

  // Busy bit storage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_ra      = r_busy[i_ra_idx];
  assign o_rb      = r_busy[i_rb_idx];
  assign o_rd      = r_busy[i_rd_idx];
  assign o_clr_hit = r_busy[i_clr_idx];

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Register-file scoreboard and writeback-port arbiter. Tracks int/FP registers
// owned by in-flight long-latency (LU) operations, stalls D on RAW/WAW/
// structural hazards, and shares the single register-file write port between
// the W stage and the LU with a starvation guard.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_d_valid                    D stage holds a real instruction
//   i_d_rs1/i_d_rs2/i_d_rd       D-stage register indices
//   i_d_use_rs1/rs2/frs1/frs2    D source-usage flags (int / FP)
//   i_d_use_rd/i_d_use_frd       D writes int / FP rd through the pipeline
//   i_d_long, i_d_long_fp        D op goes to the LU; LU target is FP file
//   o_d_stall                    hold D and upstream, bubble into E
//   i_w_wen, i_w_fwen            W stage wants the int / FP write port
//   i_lu_req, i_lu_rd, i_lu_fp   LU result ready, destination, FP target
//   o_lu_gnt                     LU result written this cycle
//   o_hold_pipe                  freeze whole pipeline for one cycle
//   o_rf_wsel                    write-port mux select
//   o_outstanding                long ops in flight
//   o_sb_err                     sticky: LU granted to a non-busy register
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_d_valid,
  input  logic [4:0]       i_d_rs1,
  input  logic [4:0]       i_d_rs2,
  input  logic [4:0]       i_d_rd,
  input  logic             i_d_use_rs1,
  input  logic             i_d_use_rs2,
  input  logic             i_d_use_frs1,
  input  logic             i_d_use_frs2,
  input  logic             i_d_use_rd,
  input  logic             i_d_use_frd,
  input  logic             i_d_long,
  input  logic             i_d_long_fp,
  output logic             o_d_stall,
  input  logic             i_w_wen,
  input  logic             i_w_fwen,
  input  logic             i_lu_req,
  input  logic [4:0]       i_lu_rd,
  input  logic             i_lu_fp,
  output logic             o_lu_gnt,
  output logic             o_hold_pipe,
  output logic             o_rf_wsel,
  output logic [CNT_W-1:0] o_outstanding,
  output logic             o_sb_err
);

  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] STARVE_C  = CNT_W'(STARVE_LIMIT);

  // Registered state
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             r_sb_err;

  // Busy table read results
  logic w_ib_rs1, w_ib_rs2, w_ib_rd, w_ib_clr;
  logic w_fb_rs1, w_fb_rs2, w_fb_rd, w_fb_clr;

  // Hazard / arbitration terms
  logic w_raw, w_waw, w_struct;
  logic w_hold, w_pipe_w, w_gnt, w_stall, w_accept;
  logic w_tgt_busy;
  logic w_iset, w_fset, w_iclr, w_fclr;

  // Integer busy table: x0 hard-wired free.
  hazard_scoreboard_busy_table #(.HARD_ZERO(1'b1)) u_ibusy (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_set     (w_iset),
    .i_set_idx (i_d_rd),
    .i_clr     (w_iclr),
    .i_clr_idx (i_lu_rd),
    .i_ra_idx  (i_d_rs1),
    .i_rb_idx  (i_d_rs2),
    .i_rd_idx  (i_d_rd),
    .o_ra      (w_ib_rs1),
    .o_rb      (w_ib_rs2),
    .o_rd      (w_ib_rd),
    .o_clr_hit (w_ib_clr)
  );

  // FP busy table: all 32 entries trackable.
  hazard_scoreboard_busy_table #(.HARD_ZERO(1'b0)) u_fbusy (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_set     (w_fset),
    .i_set_idx (i_d_rd),
    .i_clr     (w_fclr),
    .i_clr_idx (i_lu_rd),
    .i_ra_idx  (i_d_rs1),
    .i_rb_idx  (i_d_rs2),
    .i_rd_idx  (i_d_rd),
    .o_ra      (w_fb_rs1),
    .o_rb      (w_fb_rs2),
    .o_rd      (w_fb_rd),
    .o_clr_hit (w_fb_clr)
  );

  // Hazard detection and write-port arbitration. Everything here reads only
  // registered busy state, so a clear at this edge is not bypassed to D.
  always_comb begin
    w_raw = (i_d_use_rs1  & w_ib_rs1) | (i_d_use_rs2  & w_ib_rs2) |
            (i_d_use_frs1 & w_fb_rs1) | (i_d_use_frs2 & w_fb_rs2);
    w_waw = (i_d_use_rd & w_ib_rd) | (i_d_use_frd & w_fb_rd) |
            (i_d_long & (i_d_long_fp ? w_fb_rd : w_ib_rd));
    w_struct = i_d_long & (r_outstanding == MAX_OUT_C);

    // Starvation guard: once the LU has been denied STARVE_LIMIT times the
    // whole pipe freezes and its W write is withdrawn for this cycle.
    w_hold   = ~i_rst & i_lu_req & (r_starve_cnt == STARVE_C);
    w_pipe_w = (i_w_wen | i_w_fwen) & ~w_hold;
    w_gnt    = ~i_rst & i_lu_req & ~w_pipe_w;

    w_stall  = ~i_rst & ((i_d_valid & (w_raw | w_waw | w_struct)) | w_hold);
    w_accept = i_d_valid & i_d_long & ~w_stall;

    w_iset = w_accept & ~i_d_long_fp;
    w_fset = w_accept &  i_d_long_fp;
    w_iclr = w_gnt & ~i_lu_fp;
    w_fclr = w_gnt &  i_lu_fp;

    w_tgt_busy = i_lu_fp ? w_fb_clr : w_ib_clr;
  end

  // In-flight counter: issue and grant in the same cycle cancel out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_outstanding <= {CNT_W{1'b0}};
    end else begin
      case ({w_accept, w_gnt})
        2'b10: begin
          if (r_outstanding != MAX_OUT_C) begin
            r_outstanding <= r_outstanding + CNT_W'(1);
          end else begin
            r_outstanding <= r_outstanding;
          end
        end
        2'b01: begin
          if (r_outstanding != {CNT_W{1'b0}}) begin
            r_outstanding <= r_outstanding - CNT_W'(1);
          end else begin
            r_outstanding <= r_outstanding;
          end
        end
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Starvation counter: counts consecutive denied LU requests, saturating.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve_cnt <= {CNT_W{1'b0}};
    end else if (i_lu_req & ~w_gnt) begin
      if (r_starve_cnt != STARVE_C) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end else begin
        r_starve_cnt <= r_starve_cnt;
      end
    end else begin
      r_starve_cnt <= {CNT_W{1'b0}};
    end
  end

  // Sticky error: a grant whose destination was not marked busy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sb_err <= 1'b0;
    end else if (w_gnt & ~w_tgt_busy) begin
      r_sb_err <= 1'b1;
    end else begin
      r_sb_err <= r_sb_err;
    end
  end

  assign o_d_stall     = w_stall;
  assign o_lu_gnt      = w_gnt;
  assign o_hold_pipe   = w_hold;
  assign o_rf_wsel     = w_gnt ? WSEL_LU : WSEL_PIPE;
  assign o_outstanding = r_outstanding;
  assign o_sb_err      = r_sb_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (MAX_OUT=4, STARVE_LIMIT=3).
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_valid;
  logic [4:0] d_rs1, d_rs2, d_rd;
  logic       d_use_rs1, d_use_rs2, d_use_frs1, d_use_frs2;
  logic       d_use_rd, d_use_frd, d_long, d_long_fp;
  logic       w_wen, w_fwen;
  logic       lu_req;
  logic [4:0] lu_rd;
  logic       lu_fp;
  logic       d_stall, lu_gnt, hold_pipe, rf_wsel, sb_err;
  logic [3:0] outstanding;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard #(.MAX_OUT(4), .STARVE_LIMIT(3)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_d_valid     (d_valid),
    .i_d_rs1       (d_rs1),
    .i_d_rs2       (d_rs2),
    .i_d_rd        (d_rd),
    .i_d_use_rs1   (d_use_rs1),
    .i_d_use_rs2   (d_use_rs2),
    .i_d_use_frs1  (d_use_frs1),
    .i_d_use_frs2  (d_use_frs2),
    .i_d_use_rd    (d_use_rd),
    .i_d_use_frd   (d_use_frd),
    .i_d_long      (d_long),
    .i_d_long_fp   (d_long_fp),
    .o_d_stall     (d_stall),
    .i_w_wen       (w_wen),
    .i_w_fwen      (w_fwen),
    .i_lu_req      (lu_req),
    .i_lu_rd       (lu_rd),
    .i_lu_fp       (lu_fp),
    .o_lu_gnt      (lu_gnt),
    .o_hold_pipe   (hold_pipe),
    .o_rf_wsel     (rf_wsel),
    .o_outstanding (outstanding),
    .o_sb_err      (sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    d_valid = 1'b0; d_rs1 = 5'd0; d_rs2 = 5'd0; d_rd = 5'd0;
    d_use_rs1 = 1'b0; d_use_rs2 = 1'b0; d_use_frs1 = 1'b0; d_use_frs2 = 1'b0;
    d_use_rd = 1'b0; d_use_frd = 1'b0; d_long = 1'b0; d_long_fp = 1'b0;
    w_wen = 1'b0; w_fwen = 1'b0; lu_req = 1'b0; lu_rd = 5'd0; lu_fp = 1'b0;
  endtask

  // Begin a new cycle: inputs change on the falling edge.
  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic issue_long(input logic [4:0] rd, input logic fp);
    d_valid = 1'b1; d_long = 1'b1; d_long_fp = fp; d_rd = rd;
  endtask

  initial begin
    rst = 1'b1;
    idle();

    // ---- reset: outputs forced quiet even with active requests ----
    step();
    rst = 1'b1;
    issue_long(5'd1, 1'b0); lu_req = 1'b1; w_wen = 1'b1;
    #1;
    chk("rst_stall", d_stall, 0);
    chk("rst_gnt", lu_gnt, 0);
    chk("rst_hold", hold_pipe, 0);
    chk("rst_wsel", rf_wsel, 0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_out", outstanding, 0);
    chk("rst_err", sb_err, 0);

    // ---- FDIV to f5, FADD reads f5 ----
    issue_long(5'd5, 1'b1);
    #1 chk("fdiv_issue_stall", d_stall, 0);
    step();
    d_valid = 1'b1; d_use_frs1 = 1'b1; d_rs1 = 5'd5; d_use_frs2 = 1'b1; d_rs2 = 5'd2;
    d_use_frd = 1'b1; d_rd = 5'd6;
    #1;
    chk("fadd_raw_stall", d_stall, 1);
    chk("fdiv_out1", outstanding, 1);
    step();
    d_valid = 1'b1; d_use_rs1 = 1'b1; d_rs1 = 5'd5;
    #1 chk("int_x5_no_stall", d_stall, 0);
    d_valid = 1'b0; d_use_frs1 = 1'b1;
    #1 chk("invalid_no_stall", d_stall, 0);
    step();
    d_valid = 1'b1; d_use_frs1 = 1'b1; d_rs1 = 5'd5; d_use_frs2 = 1'b1; d_rs2 = 5'd2;
    lu_req = 1'b1; lu_rd = 5'd5; lu_fp = 1'b1;
    #1;
    chk("f5_gnt", lu_gnt, 1);
    chk("f5_wsel", rf_wsel, 1);
    chk("f5_no_bypass_stall", d_stall, 1);
    step();
    d_valid = 1'b1; d_use_frs1 = 1'b1; d_rs1 = 5'd5; d_use_frs2 = 1'b1; d_rs2 = 5'd2;
    #1;
    chk("fadd_released", d_stall, 0);
    chk("fdiv_out0", outstanding, 0);
    chk("fdiv_err", sb_err, 0);

    // ---- starvation: x9 busy, W_wen held high ----
    step();
    issue_long(5'd9, 1'b0);
    step();
    for (int c = 1; c <= 3; c++) begin
      w_wen = 1'b1; lu_req = 1'b1; lu_rd = 5'd9;
      d_valid = 1'b1; d_use_rd = 1'b1; d_rd = 5'd9;
      #1;
      chk($sformatf("starve_gnt_c%0d", c), lu_gnt, 0);
      chk($sformatf("starve_hold_c%0d", c), hold_pipe, 0);
      chk($sformatf("starve_wsel_c%0d", c), rf_wsel, 0);
      chk($sformatf("waw_stall_c%0d", c), d_stall, 1);
      step();
    end
    w_wen = 1'b1; lu_req = 1'b1; lu_rd = 5'd9;
    #1;
    chk("starve_hold_c4", hold_pipe, 1);
    chk("starve_gnt_c4", lu_gnt, 1);
    chk("starve_wsel_c4", rf_wsel, 1);
    chk("hold_stalls_d", d_stall, 1);
    step();
    w_wen = 1'b1;
    #1;
    chk("starve_out0", outstanding, 0);
    chk("starve_hold_off", hold_pipe, 0);
    chk("starve_err", sb_err, 0);

    // ---- structural: 4 loads to x1..x4, fifth blocked ----
    for (int r = 1; r <= 4; r++) begin
      step();
      issue_long(5'(r), 1'b0);
      #1 chk($sformatf("load_x%0d_stall", r), d_stall, 0);
    end
    step();
    issue_long(5'd5, 1'b0);
    #1;
    chk("struct_stall", d_stall, 1);
    chk("struct_out4", outstanding, 4);
    d_long = 1'b0; d_use_rs1 = 1'b1; d_rs1 = 5'd8;
    #1 chk("short_op_no_struct", d_stall, 0);
    step();
    issue_long(5'd5, 1'b0); lu_req = 1'b1; lu_rd = 5'd1;
    #1;
    chk("struct_gnt_x1", lu_gnt, 1);
    chk("struct_still_stall", d_stall, 1);
    step();
    issue_long(5'd5, 1'b0);
    #1;
    chk("struct_out3", outstanding, 3);
    chk("struct_release", d_stall, 0);
    step();
    #1 chk("struct_out4_again", outstanding, 4);

    // ---- issue x7 and grant x3 in the same cycle ----
    lu_req = 1'b1; lu_rd = 5'd2;
    #1 chk("gnt_x2", lu_gnt, 1);
    step();
    issue_long(5'd7, 1'b0); lu_req = 1'b1; lu_rd = 5'd3;
    #1;
    chk("same_cyc_stall", d_stall, 0);
    chk("same_cyc_gnt", lu_gnt, 1);
    step();
    d_valid = 1'b1; d_use_rs1 = 1'b1; d_rs1 = 5'd7;
    #1;
    chk("same_cyc_out3", outstanding, 3);
    chk("x7_busy", d_stall, 1);
    d_rs1 = 5'd3;
    #1 chk("x3_free", d_stall, 0);

    // ---- reset with 3 outstanding (x4, x5, x7) ----
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    d_valid = 1'b1; d_use_rs1 = 1'b1; d_rs1 = 5'd4; d_use_rs2 = 1'b1; d_rs2 = 5'd7;
    #1;
    chk("mid_rst_out0", outstanding, 0);
    chk("mid_rst_no_stall", d_stall, 0);
    d_use_rs1 = 1'b0; d_use_rs2 = 1'b0; d_use_rd = 1'b1; d_rd = 5'd5;
    #1 chk("mid_rst_x5_free", d_stall, 0);

    // ---- long op to x0, read x0, grant x0 -> sticky error ----
    step();
    issue_long(5'd0, 1'b0);
    #1 chk("x0_issue_stall", d_stall, 0);
    step();
    d_valid = 1'b1; d_use_rs1 = 1'b1; d_rs1 = 5'd0;
    #1;
    chk("x0_read_no_stall", d_stall, 0);
    chk("x0_out1", outstanding, 1);
    step();
    lu_req = 1'b1; lu_rd = 5'd0;
    #1;
    chk("x0_gnt", lu_gnt, 1);
    chk("x0_err_before", sb_err, 0);
    step();
    #1;
    chk("x0_err_set", sb_err, 1);
    chk("x0_out0", outstanding, 0);
    step();
    step();
    #1 chk("x0_err_sticky", sb_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
